// File: rtl/button_shaper_multi_if.sv
// rtl/button_shaper_multi_if.sv - button bundle between pushbuttons and the shaper
interface button_shaper_multi_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] button_in;
  logic               repeat_en;
  logic [NUM_BTN-1:0] button_out;
  logic [NUM_BTN-1:0] held;

  // board/stimulus side
  modport master (
    output button_in,
    output repeat_en,
    input  button_out,
    input  held
  );

  // shaper side
  modport slave (
    input  button_in,
    input  repeat_en,
    output button_out,
    output held
  );
endinterface

// File: rtl/button_shaper_multi.sv
// rtl/button_shaper_multi.sv - multi-channel pushbutton sync, debounce, one-shot and auto-repeat
module button_shaper_multi #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_PERIOD   = 5,
  parameter int CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  button_shaper_multi_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_C  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DLY_C = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PER_C = CNT_W'(REPEAT_PERIOD);

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] out_q;
  logic [NUM_BTN-1:0] held_q;
  logic [NUM_BTN-1:0] first;
  state_t             state [NUM_BTN];
  logic [CNT_W-1:0]   cnt   [NUM_BTN];
  logic [CNT_W-1:0]   rep   [NUM_BTN];

  assign bus.button_out = out_q;
  assign bus.held       = held_q;

  // two-flop synchroniser; idles high so a button held through reset looks like a new press
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= bus.button_in;
      sync2 <= sync1;
    end
  end

  // per-channel debounce / one-shot / auto-repeat FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '1;
      held_q <= '0;
      first  <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
        rep[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        out_q[i] <= 1'b1;
        case (state[i])
          IDLE: begin
            if (!sync2[i]) begin
              cnt[i] <= ONE;
              if (DB_C == ONE) begin
                state[i]  <= HELD;
                out_q[i]  <= 1'b0;
                held_q[i] <= 1'b1;
                rep[i]    <= '0;
                first[i]  <= 1'b0;
              end else begin
                state[i] <= DB_PRESS;
              end
            end
          end
          DB_PRESS: begin
            if (sync2[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + ONE;
              if (cnt[i] + ONE >= DB_C) begin
                state[i]  <= HELD;
                out_q[i]  <= 1'b0;
                held_q[i] <= 1'b1;
                rep[i]    <= '0;
                first[i]  <= 1'b0;
              end
            end
          end
          HELD: begin
            if (sync2[i]) begin
              // rep is left alone so a release bounce resumes the repeat timing
              if (DB_C == ONE) begin
                state[i]  <= IDLE;
                held_q[i] <= 1'b0;
                cnt[i]    <= '0;
              end else begin
                state[i] <= DB_REL;
                cnt[i]   <= ONE;
              end
            end else if (bus.repeat_en) begin
              if (rep[i] + ONE == (first[i] ? PER_C : DLY_C)) begin
                out_q[i] <= 1'b0;
                rep[i]   <= '0;
                first[i] <= 1'b1;
              end else begin
                rep[i] <= rep[i] + ONE;
              end
            end else begin
              rep[i]   <= '0;
              first[i] <= 1'b0;
            end
          end
          DB_REL: begin
            if (!sync2[i]) begin
              state[i] <= HELD;
            end else if (cnt[i] + ONE >= DB_C) begin
              state[i]  <= IDLE;
              held_q[i] <= 1'b0;
              cnt[i]    <= '0;
            end else begin
              cnt[i] <= cnt[i] + ONE;
            end
          end
          default: begin
            state[i]  <= IDLE;
            held_q[i] <= 1'b0;
            cnt[i]    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_shaper_multi.sv
// tb/tb_button_shaper_multi.sv - directed vector bench for button_shaper_multi
module tb_button_shaper_multi;

  logic clk;
  logic reset;

  button_shaper_multi_if #(.NUM_BTN(4)) bif ();

  button_shaper_multi #(
    .NUM_BTN(4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(5),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [3:0] btn;
    logic       ren;
    logic       rst;
    logic [3:0] exp_out;
    logic [3:0] exp_held;
    string      tag;
  } seg_t;

  seg_t tbl[$];
  int   n_cmp;
  int   n_bad;

  task automatic add(input int n, input logic [3:0] btn, input logic ren, input logic rst,
                     input logic [3:0] eo, input logic [3:0] eh, input string tag);
    seg_t s;
    s.n = n; s.btn = btn; s.ren = ren; s.rst = rst;
    s.exp_out = eo; s.exp_held = eh; s.tag = tag;
    tbl.push_back(s);
  endtask

  // drive inputs, clock once, then check both outputs one time unit after the edge
  task automatic step(input logic [3:0] btn, input logic ren, input logic rst,
                      input logic [3:0] eo, input logic [3:0] eh, input string tag);
    bif.button_in = btn;
    bif.repeat_en = ren;
    reset         = rst;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bif.button_out !== eo) begin
      n_bad++;
      $display("FAIL %s button_out: got %b want %b @%0t", tag, bif.button_out, eo, $time);
    end
    n_cmp++;
    if (bif.held !== eh) begin
      n_bad++;
      $display("FAIL %s held: got %b want %b @%0t", tag, bif.held, eh, $time);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bif.button_in = 4'hF;
    bif.repeat_en = 1'b0;
    reset = 1'b1;

    // basic press/release on channel 0, repeat off
    add(2,  4'hF, 0, 1, 4'hF, 4'h0, "reset");
    add(5,  4'hE, 0, 0, 4'hF, 4'h0, "press0_db");
    add(1,  4'hE, 0, 0, 4'hE, 4'h1, "press0_pulse");
    add(14, 4'hE, 0, 0, 4'hF, 4'h1, "press0_held");
    add(5,  4'hF, 0, 0, 4'hF, 4'h1, "rel0_db");
    add(4,  4'hF, 0, 0, 4'hF, 4'h0, "rel0_idle");
    // auto-repeat on channel 2: pulses after edges 6,16,21,26,31
    add(2,  4'hF, 1, 1, 4'hF, 4'h0, "reset");
    add(5,  4'hB, 1, 0, 4'hF, 4'h0, "rep2_db");
    add(1,  4'hB, 1, 0, 4'hB, 4'h4, "rep2_press");
    add(9,  4'hB, 1, 0, 4'hF, 4'h4, "rep2_delay");
    add(1,  4'hB, 1, 0, 4'hB, 4'h4, "rep2_first");
    add(4,  4'hB, 1, 0, 4'hF, 4'h4, "rep2_per1");
    add(1,  4'hB, 1, 0, 4'hB, 4'h4, "rep2_second");
    add(4,  4'hB, 1, 0, 4'hF, 4'h4, "rep2_per2");
    add(1,  4'hB, 1, 0, 4'hB, 4'h4, "rep2_third");
    add(4,  4'hB, 1, 0, 4'hF, 4'h4, "rep2_per3");
    add(1,  4'hF, 1, 0, 4'hB, 4'h4, "rep2_fourth");
    add(4,  4'hF, 1, 0, 4'hF, 4'h4, "rep2_rel_db");
    add(3,  4'hF, 1, 0, 4'hF, 4'h0, "rep2_idle");
    // simultaneous channels 1 and 3
    add(2,  4'hF, 0, 1, 4'hF, 4'h0, "reset");
    add(5,  4'h5, 0, 0, 4'hF, 4'h0, "sim13_db");
    add(1,  4'h5, 0, 0, 4'h5, 4'hA, "sim13_pulse");
    add(3,  4'h5, 0, 0, 4'hF, 4'hA, "sim13_held");
    // release glitch on channel 0
    add(2,  4'hF, 0, 1, 4'hF, 4'h0, "reset");
    add(5,  4'hE, 0, 0, 4'hF, 4'h0, "gl0_db");
    add(1,  4'hE, 0, 0, 4'hE, 4'h1, "gl0_pulse");
    add(4,  4'hE, 0, 0, 4'hF, 4'h1, "gl0_held");
    add(2,  4'hF, 0, 0, 4'hF, 4'h1, "gl0_glitch");
    add(12, 4'hE, 0, 0, 4'hF, 4'h1, "gl0_after");

    foreach (tbl[k]) begin
      for (int j = 0; j < tbl[k].n; j++)
        step(tbl[k].btn, tbl[k].ren, tbl[k].rst, tbl[k].exp_out, tbl[k].exp_held, tbl[k].tag);
    end

    // press bounce on channel 1: 3 low / 1 high x5, then stable low; pulse 6 edges into the stable low
    step(4'hF, 0, 1, 4'hF, 4'h0, "reset");
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 3; j++) step(4'hD, 0, 0, 4'hF, 4'h0, "bounce1_low");
      step(4'hF, 0, 0, 4'hF, 4'h0, "bounce1_high");
    end
    for (int j = 0; j < 5; j++) step(4'hD, 0, 0, 4'hF, 4'h0, "bounce1_stable");
    step(4'hD, 0, 0, 4'hD, 4'h2, "bounce1_pulse");
    for (int j = 0; j < 3; j++) step(4'hD, 0, 0, 4'hF, 4'h2, "bounce1_held");

    // reset on the pulse edge with channel 0 still down, then a fresh press
    step(4'hF, 0, 1, 4'hF, 4'h0, "reset");
    for (int j = 0; j < 5; j++) step(4'hE, 0, 0, 4'hF, 4'h0, "rst0_db");
    step(4'hE, 0, 1, 4'hF, 4'h0, "rst0_drop");
    for (int j = 0; j < 5; j++) step(4'hE, 0, 0, 4'hF, 4'h0, "rst0_redb");
    step(4'hE, 0, 0, 4'hE, 4'h1, "rst0_pulse");
    step(4'hE, 0, 0, 4'hF, 4'h1, "rst0_held");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
